// File: rtl/branch_pred_pkg.sv
// Shared types and index/counter helpers for the gshare branch predictor.
package branch_pred_pkg;

  typedef enum logic [0:0] {BP_INIT, BP_RUN} bp_state_t;

  // Saturating up/down step of a ctr_bits-wide counter, carried in 32 bits.
  function automatic logic [31:0] sat_ctr_next(input logic [31:0] ctr,
                                               input logic        taken,
                                               input int          ctr_bits);
    logic [31:0] max_val;
    max_val = (32'd1 << ctr_bits) - 32'd1;
    if (taken) return (ctr == max_val) ? ctr : ctr + 32'd1;
    else       return (ctr == 32'd0)   ? ctr : ctr - 32'd1;
  endfunction

  // History-only or gshare index; the caller keeps the low IDX_BITS.
  function automatic logic [31:0] gshare_idx(input logic [31:0] ghr_zext,
                                             input logic [31:0] pc,
                                             input int          pc_shift,
                                             input logic        hash_en);
    return hash_en ? (ghr_zext ^ (pc >> pc_shift)) : ghr_zext;
  endfunction

endpackage

// File: rtl/branch_gshare_pht.sv
// Pattern history table: two asynchronous read ports and one synchronous write port.
module branch_gshare_pht
  import branch_pred_pkg::*;
#(
  parameter int PHT_SIZE = 2048,
  parameter int CTR_BITS = 2,
  parameter int IDX_BITS = $clog2(PHT_SIZE)
) (
  input  logic                clk,
  input  logic [IDX_BITS-1:0] rd_a_idx,
  output logic [CTR_BITS-1:0] rd_a_data,
  input  logic [IDX_BITS-1:0] rd_b_idx,
  output logic [CTR_BITS-1:0] rd_b_data,
  input  logic                we,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic [CTR_BITS-1:0] wr_data
);

  // No reset: contents are established by the owner's init sweep.
  logic [CTR_BITS-1:0] pht_q [PHT_SIZE];

  assign rd_a_data = pht_q[rd_a_idx];
  assign rd_b_data = pht_q[rd_b_idx];

  always_ff @(posedge clk) begin
    if (we) pht_q[wr_idx] <= wr_data;
  end

endmodule

// File: rtl/branch_gshare_predictor.sv
// Global-history branch predictor with optional gshare hashing, PHT init sweep and statistics.
module branch_gshare_predictor
  import branch_pred_pkg::*;
#(
  parameter int PHT_SIZE  = 2048,
  parameter int CTR_BITS  = 2,
  parameter int HIST_BITS = 11,
  parameter int HASH_MODE = 1,
  parameter int PC_SHIFT  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          PC,
  output logic                 prediction,
  output logic                 ready,
  input  logic                 update_en,
  input  logic [31:0]          update_pc,
  input  logic                 update_val,
  output logic                 update_mispred,
  output logic [HIST_BITS-1:0] ghr,
  output logic [31:0]          stat_updates,
  output logic [31:0]          stat_mispreds
);

  localparam int                  IDX_BITS = $clog2(PHT_SIZE);
  localparam logic [CTR_BITS-1:0] INIT_VAL = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  bp_state_t           state_q, state_d;
  logic [IDX_BITS-1:0] init_ptr_q, init_ptr_d;
  logic [HIST_BITS-1:0] ghr_q, ghr_d;
  logic [31:0]         stat_updates_q, stat_updates_d;
  logic [31:0]         stat_mispreds_q, stat_mispreds_d;

  logic [IDX_BITS-1:0] pred_idx, upd_idx, wr_idx;
  logic [CTR_BITS-1:0] pred_ctr, upd_ctr, upd_ctr_next, wr_data;
  logic                run, accept, we;

  assign run      = (state_q == BP_RUN);
  assign accept   = run & update_en;
  assign pred_idx = IDX_BITS'(gshare_idx(32'(ghr_q), PC, PC_SHIFT, HASH_MODE != 0));
  assign upd_idx  = IDX_BITS'(gshare_idx(32'(ghr_q), update_pc, PC_SHIFT, HASH_MODE != 0));
  assign upd_ctr_next = CTR_BITS'(sat_ctr_next(32'(upd_ctr), update_val, CTR_BITS));

  // The sweep owns the write port during INIT; resolved updates own it in RUN.
  assign we      = !run | update_en;
  assign wr_idx  = run ? upd_idx      : init_ptr_q;
  assign wr_data = run ? upd_ctr_next : INIT_VAL;

  branch_gshare_pht #(
    .PHT_SIZE (PHT_SIZE),
    .CTR_BITS (CTR_BITS),
    .IDX_BITS (IDX_BITS)
  ) u_pht (
    .clk       (clk),
    .rd_a_idx  (pred_idx),
    .rd_a_data (pred_ctr),
    .rd_b_idx  (upd_idx),
    .rd_b_data (upd_ctr),
    .we        (we),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data)
  );

  assign ready          = run;
  assign prediction     = run & pred_ctr[CTR_BITS-1];
  assign update_mispred = accept & (upd_ctr[CTR_BITS-1] != update_val);
  assign ghr            = ghr_q;
  assign stat_updates   = stat_updates_q;
  assign stat_mispreds  = stat_mispreds_q;

  always_comb begin
    state_d         = state_q;
    init_ptr_d      = init_ptr_q;
    ghr_d           = ghr_q;
    stat_updates_d  = stat_updates_q;
    stat_mispreds_d = stat_mispreds_q;
    if (!run) begin
      init_ptr_d = init_ptr_q + IDX_BITS'(1);
      if (init_ptr_q == IDX_BITS'(PHT_SIZE - 1)) state_d = BP_RUN;
    end else if (update_en) begin
      // Truncating the concatenation shifts in the outcome for any HIST_BITS >= 1.
      ghr_d = HIST_BITS'({ghr_q, update_val});
      if (stat_updates_q != 32'hFFFF_FFFF) stat_updates_d = stat_updates_q + 32'd1;
      if (update_mispred && stat_mispreds_q != 32'hFFFF_FFFF)
        stat_mispreds_d = stat_mispreds_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= BP_INIT;
      init_ptr_q      <= '0;
      ghr_q           <= '0;
      stat_updates_q  <= '0;
      stat_mispreds_q <= '0;
    end else begin
      state_q         <= state_d;
      init_ptr_q      <= init_ptr_d;
      ghr_q           <= ghr_d;
      stat_updates_q  <= stat_updates_d;
      stat_mispreds_q <= stat_mispreds_d;
    end
  end

endmodule
